// File: rtl/imc_result_readback.sv
// IMC/SA result readback: FWFT result FIFOs, ADC word serialiser and
// status word on one registered read port.

module imc_rb_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 16,
    parameter int CW    = 5
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic [CW-1:0] cnt_o,
    output logic         empty_o,
    output logic         full_o,
    output logic         ovf_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign cnt_o   = cnt_q;
    assign dout_o  = mem_q[rp_q];

    // A pop in the same cycle frees the slot, so a push into a full FIFO is legal.
    assign do_pop  = pop_i & ~empty_o & ~flush_i;
    assign do_push = push_i & ~flush_i & (~full_o | do_pop);
    assign ovf_o   = push_i & ~flush_i & full_o & ~do_pop;

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wp_d = wp_q + AW'(1);
            if (do_pop)  rp_d = rp_q + AW'(1);
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wp_q] <= din_i;
    end
endmodule

module imc_result_readback #(
    parameter int CH       = 16,
    parameter int ADC_BITS = 4,
    parameter int SA_W     = 16,
    parameter int BUS_W    = 32,
    parameter int DEPTH    = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         flush,
    input  logic [CH*ADC_BITS-1:0]       imc_data_in,
    input  logic                         imc_wr_en,
    input  logic [SA_W-1:0]              sa_data_in,
    input  logic                         sa_wr_en,
    input  logic [1:0]                   src_sel,
    input  logic                         rd_req,
    output logic [BUS_W-1:0]             rd_data,
    output logic                         rd_valid,
    output logic                         imc_empty,
    output logic                         imc_full,
    output logic                         sa_empty,
    output logic                         sa_full,
    output logic [$clog2(DEPTH+1)-1:0]   imc_cnt,
    output logic [$clog2(DEPTH+1)-1:0]   sa_cnt,
    output logic                         overflow,
    output logic                         underflow,
    output logic [3:0]                   beat_idx
);
    localparam int WIDE_W = CH * ADC_BITS;
    localparam int BEATS  = (WIDE_W + BUS_W - 1) / BUS_W;
    localparam int CW     = $clog2(DEPTH + 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t               state_q, state_d;
    logic [3:0]           beat_q, beat_d;
    logic [BUS_W-1:0]     rd_data_q, rd_data_d;
    logic                 rd_valid_q, rd_valid_d;
    logic                 ovf_q, ovf_d, unf_q, unf_d;

    logic [WIDE_W-1:0]      imc_head;
    logic [SA_W-1:0]        sa_head;
    logic [BEATS*BUS_W-1:0] imc_pad;
    logic [BUS_W-1:0]       beat_word, status_w;
    logic imc_ovf, sa_ovf, imc_pop;
    logic imc_sel, sa_sel, rd_imc, rd_sa, empty_rd, last_beat;

    assign imc_sel   = (src_sel == 2'b01);
    assign sa_sel    = (src_sel == 2'b10);
    assign rd_imc    = rd_req & ~flush & imc_sel & ~imc_empty;
    assign rd_sa     = rd_req & ~flush & sa_sel & ~sa_empty;
    assign empty_rd  = rd_req & ~flush &
                       ((imc_sel & imc_empty) | (sa_sel & sa_empty));
    assign last_beat = (beat_q == 4'(BEATS - 1));

    imc_rb_fifo #(.W(WIDE_W), .DEPTH(DEPTH), .CW(CW)) u_imc_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush_i (flush),
        .push_i  (imc_wr_en),
        .pop_i   (imc_pop),
        .din_i   (imc_data_in),
        .dout_o  (imc_head),
        .cnt_o   (imc_cnt),
        .empty_o (imc_empty),
        .full_o  (imc_full),
        .ovf_o   (imc_ovf)
    );

    imc_rb_fifo #(.W(SA_W), .DEPTH(DEPTH), .CW(CW)) u_sa_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush_i (flush),
        .push_i  (sa_wr_en),
        .pop_i   (rd_sa),
        .din_i   (sa_data_in),
        .dout_o  (sa_head),
        .cnt_o   (sa_cnt),
        .empty_o (sa_empty),
        .full_o  (sa_full),
        .ovf_o   (sa_ovf)
    );

    always_comb begin
        imc_pad = '0;
        imc_pad[WIDE_W-1:0] = imc_head;
    end

    assign beat_word = imc_pad[beat_q*BUS_W +: BUS_W];

    // An empty read reports the underflow it is raising.
    always_comb begin
        status_w        = '0;
        status_w[4:0]   = 5'(imc_cnt);
        status_w[9:5]   = 5'(sa_cnt);
        status_w[10]    = imc_empty;
        status_w[11]    = imc_full;
        status_w[12]    = sa_empty;
        status_w[13]    = sa_full;
        status_w[14]    = ovf_q;
        status_w[15]    = unf_q | empty_rd;
        status_w[19:16] = beat_q;
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        imc_pop = 1'b0;
        if (flush) begin
            state_d = IDLE;
            beat_d  = '0;
        end else if (rd_imc) begin
            unique case (state_q)
                IDLE: begin
                    if (last_beat) begin
                        imc_pop = 1'b1;
                    end else begin
                        beat_d  = 4'd1;
                        state_d = STREAM;
                    end
                end
                STREAM: begin
                    if (last_beat) begin
                        imc_pop = 1'b1;
                        beat_d  = '0;
                        state_d = IDLE;
                    end else begin
                        beat_d  = beat_q + 4'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        ovf_d      = ovf_q | imc_ovf | sa_ovf;
        unf_d      = unf_q | empty_rd;
        if (flush) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else if (rd_req) begin
            rd_valid_d = 1'b1;
            unique case (1'b1)
                rd_imc:  rd_data_d = beat_word;
                rd_sa:   rd_data_d = BUS_W'(sa_head);
                default: rd_data_d = status_w;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign beat_idx  = beat_q;
endmodule

// File: tb/tb_imc_result_readback.sv
// Scoreboard bench for imc_result_readback: expected read words are queued
// when a read is issued and matched against each rd_valid pulse.

module tb_imc_result_readback;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic [63:0] imc_data_in;
    logic        imc_wr_en;
    logic [15:0] sa_data_in;
    logic        sa_wr_en;
    logic [1:0]  src_sel;
    logic        rd_req;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        imc_empty, imc_full, sa_empty, sa_full;
    logic [4:0]  imc_cnt, sa_cnt;
    logic        overflow, underflow;
    logic [3:0]  beat_idx;

    int tests = 0;
    int fails = 0;
    logic [31:0] sb[$];

    imc_result_readback dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush),
        .imc_data_in (imc_data_in),
        .imc_wr_en   (imc_wr_en),
        .sa_data_in  (sa_data_in),
        .sa_wr_en    (sa_wr_en),
        .src_sel     (src_sel),
        .rd_req      (rd_req),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .imc_empty   (imc_empty),
        .imc_full    (imc_full),
        .sa_empty    (sa_empty),
        .sa_full     (sa_full),
        .imc_cnt     (imc_cnt),
        .sa_cnt      (sa_cnt),
        .overflow    (overflow),
        .underflow   (underflow),
        .beat_idx    (beat_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] st(input int ic, input int sc,
        input bit ie, input bit ifl, input bit se, input bit sf,
        input bit ov, input bit un, input int bi);
        logic [31:0] w;
        w = '0;
        w[4:0]   = 5'(ic);
        w[9:5]   = 5'(sc);
        w[10]    = ie;
        w[11]    = ifl;
        w[12]    = se;
        w[13]    = sf;
        w[14]    = ov;
        w[15]    = un;
        w[19:16] = 4'(bi);
        return w;
    endfunction

    always @(negedge clk) begin
        if (reset_n && rd_valid) begin
            if (sb.size() == 0) chk("rd_valid_unexp", 64'(rd_valid), 64'd0);
            else chk("rd_data", 64'(rd_data), 64'(sb.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_imc(input logic [63:0] d);
        imc_data_in = d;
        imc_wr_en   = 1'b1;
        tick();
        imc_wr_en   = 1'b0;
    endtask

    task automatic rd(input logic [1:0] sel, input logic [31:0] exp);
        src_sel = sel;
        rd_req  = 1'b1;
        sb.push_back(exp);
        tick();
        rd_req  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0; flush = 1'b0; imc_data_in = '0; imc_wr_en = 1'b0;
        sa_data_in = '0; sa_wr_en = 1'b0; src_sel = 2'b00; rd_req = 1'b0;
        #2;
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_imc_empty", 64'(imc_empty), 64'd1);
        chk("rst_sa_empty", 64'(sa_empty), 64'd1);
        chk("rst_imc_cnt", 64'(imc_cnt), 64'd0);
        chk("rst_beat", 64'(beat_idx), 64'd0);
        #10 reset_n = 1'b1;
        tick();

        // Two-beat serialisation of one ADC word
        push_imc(64'hFEDC_BA98_7654_3210);
        chk("t1_cnt0", 64'(imc_cnt), 64'd1);
        rd(2'b01, 32'h7654_3210);
        chk("t1_cnt1", 64'(imc_cnt), 64'd1);
        chk("t1_beat1", 64'(beat_idx), 64'd1);
        rd(2'b01, 32'hFEDC_BA98);
        chk("t1_cnt2", 64'(imc_cnt), 64'd0);
        chk("t1_beat2", 64'(beat_idx), 64'd0);

        // Overfill by one
        for (int i = 0; i < 17; i++) push_imc(64'(i));
        chk("t2_cnt", 64'(imc_cnt), 64'd16);
        chk("t2_full", 64'(imc_full), 64'd1);
        chk("t2_ovf", 64'(overflow), 64'd1);
        rd(2'b00, st(16, 0, 0, 1, 1, 0, 1, 0, 0));

        // Flush beats a concurrent read
        tick();
        flush = 1'b1; rd_req = 1'b1; src_sel = 2'b01;
        tick();
        flush = 1'b0; rd_req = 1'b0;
        chk("t3_rd_valid", 64'(rd_valid), 64'd0);
        chk("t3_cnt", 64'(imc_cnt), 64'd0);
        chk("t3_ovf", 64'(overflow), 64'd0);
        chk("t3_unf", 64'(underflow), 64'd0);
        chk("t3_empty", 64'(imc_empty), 64'd1);

        // Empty SA read
        rd(2'b10, 32'h0000_9400);
        chk("t4_unf", 64'(underflow), 64'd1);
        chk("t4_sa_cnt", 64'(sa_cnt), 64'd0);
        chk("t4_imc_cnt", 64'(imc_cnt), 64'd0);
        flush = 1'b1; tick(); flush = 1'b0;
        chk("t4_unf_clr", 64'(underflow), 64'd0);

        // Interrupted stream resumes at the held beat
        push_imc(64'h1111_1111_2222_2222);
        rd(2'b01, 32'h2222_2222);
        rd(2'b00, st(1, 0, 0, 0, 1, 0, 0, 0, 1));
        chk("t5_beat", 64'(beat_idx), 64'd1);
        rd(2'b01, 32'h1111_1111);
        chk("t5_cnt", 64'(imc_cnt), 64'd0);
        chk("t5_beat0", 64'(beat_idx), 64'd0);

        // Push into a full FIFO on the last-beat pop
        for (int i = 0; i < 16; i++) push_imc({32'(i + 256), 32'(i)});
        chk("t6_cnt_full", 64'(imc_cnt), 64'd16);
        rd(2'b01, 32'd0);
        imc_data_in = 64'hDEAD_BEEF_CAFE_F00D;
        imc_wr_en = 1'b1; rd_req = 1'b1; src_sel = 2'b01;
        sb.push_back(32'd256);
        tick();
        imc_wr_en = 1'b0; rd_req = 1'b0;
        chk("t6_cnt", 64'(imc_cnt), 64'd16);
        chk("t6_ovf", 64'(overflow), 64'd0);
        chk("t6_full", 64'(imc_full), 64'd1);
        sa_data_in = 16'hA5A5; sa_wr_en = 1'b1; tick(); sa_wr_en = 1'b0;
        chk("t6_sa_cnt", 64'(sa_cnt), 64'd1);
        rd(2'b10, 32'h0000_A5A5);
        chk("t6_sa_cnt0", 64'(sa_cnt), 64'd0);

        // Async reset mid-stream
        rd(2'b01, 32'd1);
        chk("t7_beat", 64'(beat_idx), 64'd1);
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("t7_rd_data", 64'(rd_data), 64'd0);
        chk("t7_rd_valid", 64'(rd_valid), 64'd0);
        chk("t7_cnt", 64'(imc_cnt), 64'd0);
        chk("t7_beat0", 64'(beat_idx), 64'd0);
        chk("t7_empty", 64'(imc_empty), 64'd1);
        chk("t7_full", 64'(imc_full), 64'd0);
        #2 reset_n = 1'b1;
        tick();
        tick();
        chk("sb_drain", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
